score_display: RTL and testbench
================================

Name: score_display

Overview:
Multi-digit decimal display driver for the DE2 HEX displays, converting a binary score/combo count to active-low seven-segment patterns.
- Sequential shift-add-3 (double-dabble) binary-to-BCD converter, controlled by a load/busy/done handshake.
- Registered multi-digit outputs with overflow indication.
- Parametrised successor to the single-digit hex decoder; sits between game score logic and HEX pins.

Parameters:
- NUM_DIGITS, 4: number of decimal digits and HEX displays driven (1..8).
- BIN_WIDTH, 14: width of the binary input value (1..27).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- load  input  1  request conversion of value; sampled only when idle.
- value  input  BIN_WIDTH  unsigned binary number to display.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when hex has been updated.
- overflow  output  1  last converted value was >= 10^NUM_DIGITS.
- hex  output  7*NUM_DIGITS  segments; digit k at [7k+6:7k], digit 0 is least significant; per digit bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; active-low (0 = lit).

Behaviour:
- Reset, clk edge with rst=1: state IDLE; busy=0; done=0; overflow=0; hex all 7'h7F (all dark); shift/BCD registers cleared. Reset wins over load and aborts any in-progress conversion, with no done pulse.
- IDLE: if load=1, capture value into the shift register, clear the BCD register and the overflow sticky bit, set the counter to BIN_WIDTH, and go to SHIFT. busy=1 from the next cycle.
- SHIFT, one bit per cycle:
  - Add 3 to each BCD nibble >= 5.
  - Then shift {bcd, shift} left by 1.
  - If the bit leaving the top nibble is 1, or a top-nibble add-3 carries out, set the overflow sticky bit.
  - Decrement the counter. After the BIN_WIDTH-th shift, go to UPDATE.
- UPDATE, one cycle: register hex from BCD, apply blanking/overflow rules, set overflow from the sticky bit, pulse done=1, set busy=0, return to IDLE.
- Latency: load sampled at edge N; hex, overflow and done valid after edge N+BIN_WIDTH+1. busy=1 for exactly BIN_WIDTH+1 cycles.
- load while busy is ignored; no queueing. load in the same cycle as the done pulse is accepted (state is IDLE again). hex holds its value between updates.
- Digit encoding, active-low:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
- Overflow (value >= 10^NUM_DIGITS): every digit shows dash 7'h3F (g only) and overflow=1. Otherwise overflow=0.
- BCD nibbles are never >9 after a correct conversion. Any nibble >9 encodes as blank 7'h7F.

Optional Feature:
LZ_BLANK_EN
- Defined: leading zero digits show blank 7'h7F, scanning from the most significant digit down to the first nonzero digit. Digit 0 is always shown, so value 0 displays a single "0". Overflow dashes are never blanked.
- Undefined: every digit shows its numeral, including leading zeros.

Decomposition:
- Package score_display_pkg:
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - Function or constant array for the BCD-to-segment patterns above.
  - State enum {IDLE, SHIFT, UPDATE}.
- Sub-module seg7_digit_encoder: combinational 4-bit BCD plus blank flag to 7-bit active-low segments. Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset: assert rst 2 cycles -> hex=28'hFFFFFFF, busy=0, done=0, overflow=0.
- Latency and 4-digit value: load value=1234 -> busy high 15 cycles; done pulse at cycle 15; hex digits 3..0 = 7'h79, 7'h24, 7'h30, 7'h19; overflow=0.
- Zero and leading-zero handling: value=7 and value=0 with LZ_BLANK_EN -> "   7" and "   0" (upper digits 7'h7F). Without the macro -> 7'h40 in upper digits.
- Overflow boundary:
  - value=9999 -> all digits 7'h10, overflow=0.
  - value=10000 -> all digits 7'h3F, overflow=1.
  - value=16383 -> same as 10000.
- Handshake and reset abort:
  - load pulse at cycle 3 of a conversion is ignored; only one done; hex reflects the first value.
  - rst at cycle 5 of a conversion -> no done; hex dark; a subsequent load converts correctly.
- Parameter sweep: NUM_DIGITS=2, BIN_WIDTH=7 -> value=99 gives "99"; value=100 gives dashes and overflow=1; busy lasts 8 cycles.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared constants, FSM states and BCD-to-segment patterns for score_display.
// Segment bit order: bit0=a .. bit6=g. Patterns are active-low.
package score_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    // Out-of-range nibbles go dark rather than showing a bogus glyph
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/score_display_digit_encoder.sv
// One decimal digit: 4-bit BCD plus blank flag to active-low seven-segment pattern.
module seg7_digit_encoder
    import score_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = i_blank ? SEG_BLANK : bcd_to_seg(i_bcd);

endmodule

// File: rtl/score_display.sv
// Binary score to multi-digit HEX display driver using a serial double-dabble converter.
// Optional macro LZ_BLANK_EN: blank leading zero digits (digit 0 always shown).
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BIN_WIDTH-1:0]    value,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned HEX_W = 7 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    state_t               r_state;
    logic [BIN_WIDTH-1:0] r_shift;
    logic [BCD_W-1:0]     r_bcd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_sticky;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overflow;
    logic [HEX_W-1:0]     r_hex;

    state_t               w_state_nxt;
    logic [BIN_WIDTH-1:0] w_shift_nxt;
    logic [BCD_W-1:0]     w_bcd_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_sticky_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_ovf_nxt;
    logic [HEX_W-1:0]     w_hex_nxt;

    logic [BCD_W-1:0]      w_adj;
    logic                  w_top_carry;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [HEX_W-1:0]      w_seg;

    // Add-3 correction per nibble and segment encoding per digit
    for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_digit
        assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3
                                                           : r_bcd[4*k +: 4];

        seg7_digit_encoder u_enc (
            .i_bcd   (r_bcd[4*k +: 4]),
            .i_blank (w_blank[k]),
            .o_seg_c (w_seg[7*k +: 7])
        );
    end

    // A top nibble of 13..15 would carry out of the add-3; only reachable once already overflowed
    assign w_top_carry = (r_bcd[BCD_W-1 -: 4] >= 4'd13);

    always_comb begin
        logic seen_nz;
        w_blank = '0;
        seen_nz = 1'b0;
`ifdef LZ_BLANK_EN
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            if (r_bcd[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            w_blank[k] = ~seen_nz;
        end
`endif
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bcd_nxt    = r_bcd;
        w_cnt_nxt    = r_cnt;
        w_sticky_nxt = r_sticky;
        w_hex_nxt    = r_hex;
        w_ovf_nxt    = r_overflow;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (load) begin
                    w_shift_nxt  = value;
                    w_bcd_nxt    = '0;
                    w_sticky_nxt = 1'b0;
                    w_cnt_nxt    = CNT_W'(BIN_WIDTH);
                    w_state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                w_bcd_nxt   = {w_adj[BCD_W-2:0], r_shift[BIN_WIDTH-1]};
                w_shift_nxt = r_shift << 1;
                if (w_adj[BCD_W-1] || w_top_carry) begin
                    w_sticky_nxt = 1'b1;
                end
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                w_hex_nxt   = r_sticky ? {NUM_DIGITS{SEG_DASH}} : w_seg;
                w_ovf_nxt   = r_sticky;
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_sticky   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_hex      <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bcd      <= w_bcd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sticky   <= w_sticky_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_overflow <= w_ovf_nxt;
            r_hex      <= w_hex_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign hex      = r_hex;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: default 4x14 instance plus a 2-digit, 7-bit instance.
module tb_score_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        load1, load2;
    logic [13:0] value1;
    logic [6:0]  value2;
    logic        busy1, done1, ovf1;
    logic        busy2, done2, ovf2;
    logic [27:0] hex1;
    logic [13:0] hex2;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        int unsigned v;
        logic [27:0] hex;
        logic        ovf;
    } vec_t;

    always #5 clk = ~clk;

    score_display #(.NUM_DIGITS(4), .BIN_WIDTH(14)) dut (
        .clk(clk), .rst(rst), .load(load1), .value(value1),
        .busy(busy1), .done(done1), .overflow(ovf1), .hex(hex1)
    );

    score_display #(.NUM_DIGITS(2), .BIN_WIDTH(7)) dut2 (
        .clk(clk), .rst(rst), .load(load2), .value(value2),
        .busy(busy2), .done(done2), .overflow(ovf2), .hex(hex2)
    );

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r = 1;
        for (int i = 0; i < int'(n); i++) r = r * 10;
        return r;
    endfunction

    function automatic logic model_ovf(input int unsigned v, input int unsigned nd);
        return v >= pow10(nd);
    endfunction

    // Display as a person would read it: decimal digits, dashes on overflow
    function automatic logic [55:0] model_hex(input int unsigned v, input int unsigned nd);
        logic [55:0] h;
        logic [6:0]  s;
        int unsigned q;
        int unsigned d;
        h = '0;
        q = 1;
        for (int k = 0; k < int'(nd); k++) begin
            d = (v / q) % 10;
            s = SEG_TAB[d];
`ifdef LZ_BLANK_EN
            if (k > 0 && v < q) s = 7'h7F;
`endif
            if (model_ovf(v, nd)) s = 7'h3F;
            h[7*k +: 7] = s;
            q = q * 10;
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; load is sampled on the following posedge
    task automatic kick(input bit sel, input int unsigned v);
        if (sel) begin
            load2  = 1'b1;
            value2 = 7'(v);
        end else begin
            load1  = 1'b1;
            value1 = 14'(v);
        end
        @(negedge clk);
        load1 = 1'b0;
        load2 = 1'b0;
    endtask

    // Counts busy cycles until done, then checks result; returns on the done cycle
    task automatic wait_result(input bit sel, input string name,
                               input logic [55:0] exp_hex, input logic exp_ovf);
        int unsigned busy_n = 0;
        int unsigned guard  = 0;
        int unsigned w      = sel ? 7 : 14;
        logic [55:0] act_hex;
        while (!(sel ? done2 : done1) && guard < 100) begin
            if (sel ? busy2 : busy1) busy_n++;
            guard++;
            @(negedge clk);
        end
        chk({name, " done_seen"}, 64'(guard < 100), 64'(1));
        chk({name, " busy_len"}, 64'(busy_n), 64'(w + 1));
        act_hex = sel ? 56'(hex2) : 56'(hex1);
        chk({name, " hex"}, 64'(act_hex), 64'(exp_hex));
        chk({name, " ovf"}, 64'(sel ? ovf2 : ovf1), 64'(exp_ovf));
        chk({name, " busy_at_done"}, 64'(sel ? busy2 : busy1), 64'(0));
    endtask

    task automatic done_falls(input bit sel, input string name);
        @(negedge clk);
        chk({name, " done_pulse"}, 64'(sel ? done2 : done1), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tab [8];
        int unsigned v;
        int          dones;
        logic [27:0] hex_at;

        tab[0] = '{v: 1234,  hex: {7'h79, 7'h24, 7'h30, 7'h19}, ovf: 1'b0};
        tab[1] = '{v: 10000, hex: {4{7'h3F}},                   ovf: 1'b1};
        tab[2] = '{v: 9999,  hex: {4{7'h10}},                   ovf: 1'b0};
        tab[3] = '{v: 16383, hex: {4{7'h3F}},                   ovf: 1'b1};
`ifdef LZ_BLANK_EN
        tab[4] = '{v: 7,     hex: {7'h7F, 7'h7F, 7'h7F, 7'h78}, ovf: 1'b0};
        tab[5] = '{v: 0,     hex: {7'h7F, 7'h7F, 7'h7F, 7'h40}, ovf: 1'b0};
        tab[6] = '{v: 905,   hex: {7'h7F, 7'h10, 7'h40, 7'h12}, ovf: 1'b0};
`else
        tab[4] = '{v: 7,     hex: {7'h40, 7'h40, 7'h40, 7'h78}, ovf: 1'b0};
        tab[5] = '{v: 0,     hex: {7'h40, 7'h40, 7'h40, 7'h40}, ovf: 1'b0};
        tab[6] = '{v: 905,   hex: {7'h40, 7'h10, 7'h40, 7'h12}, ovf: 1'b0};
`endif
        tab[7] = '{v: 5086,  hex: {7'h12, 7'h40, 7'h00, 7'h02}, ovf: 1'b0};

        rst    = 1'b1;
        load1  = 1'b0;
        load2  = 1'b0;
        value1 = '0;
        value2 = '0;
        repeat (2) @(negedge clk);
        chk("reset hex", 64'(hex1), 64'(28'hFFFFFFF));
        chk("reset busy", 64'(busy1), 64'(0));
        chk("reset done", 64'(done1), 64'(0));
        chk("reset ovf", 64'(ovf1), 64'(0));
        chk("reset hex2", 64'(hex2), 64'(14'h3FFF));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            kick(0, tab[i].v);
            wait_result(0, $sformatf("tab%0d(%0d)", i, tab[i].v), 56'(tab[i].hex), tab[i].ovf);
            done_falls(0, $sformatf("tab%0d", i));
        end

        // Load in the same cycle as done is accepted
        kick(0, 4321);
        wait_result(0, "b2b_first", model_hex(4321, 4), 1'b0);
        kick(0, 56);
        chk("b2b done_low", 64'(done1), 64'(0));
        chk("b2b busy_high", 64'(busy1), 64'(1));
        wait_result(0, "b2b_second", model_hex(56, 4), 1'b0);
        done_falls(0, "b2b_second");

        // A load during conversion is dropped
        kick(0, 2468);
        repeat (2) @(negedge clk);
        load1  = 1'b1;
        value1 = 14'd1357;
        @(negedge clk);
        load1  = 1'b0;
        dones  = 0;
        hex_at = '0;
        for (int c = 0; c < 40; c++) begin
            if (done1) begin
                dones++;
                hex_at = hex1;
            end
            @(negedge clk);
        end
        chk("ignore_load done_count", 64'(dones), 64'(1));
        chk("ignore_load hex", 64'(hex_at), 64'(model_hex(2468, 4)));

        // Reset mid-conversion aborts without done
        kick(0, 5555);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (done1) dones++;
            @(negedge clk);
        end
        chk("abort done_count", 64'(dones), 64'(0));
        chk("abort hex", 64'(hex1), 64'(28'hFFFFFFF));
        chk("abort busy", 64'(busy1), 64'(0));
        chk("abort ovf", 64'(ovf1), 64'(0));
        kick(0, 808);
        wait_result(0, "after_abort", model_hex(808, 4), 1'b0);
        done_falls(0, "after_abort");

        // Small instance: boundary at 100
        kick(1, 99);
        wait_result(1, "d2_99", 56'({7'h10, 7'h10}), 1'b0);
        done_falls(1, "d2_99");
        kick(1, 100);
        wait_result(1, "d2_100", 56'({7'h3F, 7'h3F}), 1'b1);
        done_falls(1, "d2_100");

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(9990, 10010);
            else                           v = $urandom_range(0, 16383);
            kick(0, v);
            wait_result(0, $sformatf("rnd%0d(%0d)", i, v), model_hex(v, 4), model_ovf(v, 4));
            done_falls(0, "rnd");
        end

        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(0, 127);
            kick(1, v);
            wait_result(1, $sformatf("rnd2_%0d(%0d)", i, v), model_hex(v, 2), model_ovf(v, 2));
            done_falls(1, "rnd2");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
